uart_mmio_fifo: RTL and testbench
=================================

# uart_mmio_fifo

Memory-mapped UART front end for the MIPS150 datapath. It replaces the single-byte UART decoder with parametrised TX and RX FIFOs, sticky error flags and an optional traffic-statistics register. It sits between the CPU memory stage (address, store data, load/store strobes) and the existing `UART` module's ready/valid byte interface.

## Interface

**Parameters**
- `TX_DEPTH`, default 8: TX FIFO entries; power of two, ≥2.
- `RX_DEPTH`, default 8: RX FIFO entries; power of two, ≥2.
- `BASE_ADDR`, default 32'h8000_0000: base of the 32-byte register window.

**Ports** (clock and reset first)
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `addr` in 32: byte address from the memory stage.
- `wd` in 32: store data.
- `we` in 1: store strobe, valid for one cycle per access.
- `re` in 1: load strobe, valid for one cycle per access.
- `hit` out 1: combinational; asserted when `addr[31:5]` equals `BASE_ADDR[31:5]`.
- `rdata` out 32: load data, registered.
- `tx_data` out 8: byte to UART `DataIn`.
- `tx_valid` out 1: to UART `DataInValid`.
- `tx_ready` in 1: from UART `DataInReady`.
- `rx_data` in 8: from UART `DataOut`.
- `rx_valid` in 1: from UART `DataOutValid`.
- `rx_ready` out 1: to UART `DataOutReady`.
- `irq` out 1: level-high interrupt, registered.

## Operation

**Register map** (offsets from `BASE_ADDR`; accesses with `hit` low are ignored)
- 0x00 STATUS (read-only bits 3:0, write-1-to-clear bits 5:4)
  - bit0 tx_not_full
  - bit1 rx_not_empty
  - bit2 tx_empty
  - bit3 rx_full
  - bit4 tx_overflow (sticky)
  - bit5 rx_overrun (sticky)
  - bits 31:6 read 0.
- 0x04 RXDATA
  - A read returns `{24'b0, head}` and pops one entry.
  - A read when the FIFO is empty returns 0 and does not pop.
- 0x08 TXDATA
  - A write pushes `wd[7:0]`.
  - A write when the FIFO is full is dropped and sets tx_overflow.
- 0x0C IRQEN
  - Bit0 enables the rx_not_empty interrupt; bit1 enables the tx_empty interrupt.
  - Read/write. Reset value 0.
- Unmapped offsets read 0. Writes to unmapped offsets are ignored.

**Interrupt and UART-side rules**
- `irq` = (IRQEN[0] & rx_not_empty) | (IRQEN[1] & tx_empty) | tx_overflow | rx_overrun.
- `rx_ready` is constantly 1; the UART receiver cannot be back-pressured.
  - An `rx_valid` byte arriving while the RX FIFO is full is discarded and sets rx_overrun.
- `tx_valid` = TX FIFO not empty. `tx_data` = TX head.
  - The head pops on `tx_valid & tx_ready`.

**Simultaneous events**
- Push and pop in the same cycle on either FIFO: occupancy is unchanged.
  - This is legal when the FIFO is full: the pop frees the slot, no overflow is flagged, and the pushed byte is accepted.
  - This is legal when the FIFO is empty for TX only: the pushed byte is not visible to the UART until the next cycle.
  - For RX on empty, the CPU read returns 0 and the arriving byte is stored.
- A STATUS W1C write in the same cycle as a new overflow event: the set wins.

**Pointers**
- Each FIFO uses $clog2(DEPTH)+1-bit read and write pointers.
  - full = MSBs differ and the remaining bits are equal.
  - empty = pointers equal.
  - Pointers wrap naturally.

## Timing

- Load latency 1: `rdata` is valid the cycle after `re`. The pop (and any flag change) takes effect at that same clock edge.
- `rdata` holds its value until the next qualifying `re`.
- Store takes effect at the clock edge ending the `we` cycle. A STATUS read in the following cycle reflects it.
- TX throughput: one byte per cycle when `tx_ready` is held high.
- Reset (asynchronous, any time including mid-transfer):
  - Pointers, sticky flags, IRQEN, `rdata` and `irq` go to 0.
  - `tx_valid` goes to 0 and `rx_ready` goes to 1.
  - FIFO storage contents are don't-care.
  - Release is synchronous to `clk` through the existing top-level reset logic.

## Configuration

- `UART_MMIO_STATS_EN` defined: adds a STATS register at 0x10.
  - Read returns `{rx_drop_count[15:0], tx_byte_count[15:0]}`.
  - Both counters saturate at 16'hFFFF.
  - tx_byte_count counts UART-side pops; rx_drop_count counts discarded RX bytes.
  - Any write to 0x10 clears both counters. A clear in the same cycle as an increment leaves the counter at 0.
- Undefined: offset 0x10 reads 0 and no counter flops are synthesised.

## Structure

- Shared package `uart_mmio_pkg`:
  - register offset constants (`OFF_STATUS`, `OFF_RXDATA`, `OFF_TXDATA`, `OFF_IRQEN`, `OFF_STATS`);
  - STATUS and IRQEN bit-index constants.
- One sub-module `sync_fifo`:
  - parameters `WIDTH`, `DEPTH`;
  - ports `push`, `pop`, `din`, `dout`, `full`, `empty`;
  - instantiated twice (TX and RX). Push-when-full and pop-when-empty are ignored inside `sync_fifo`.
- Top level holds the address decode, flags, IRQ, the `rdata` register and the optional stats.

## Test plan

- **Reset:** assert `rst`=0 mid-TX burst → `tx_valid`=0, STATUS reads 0x05, `irq`=0 after release.
- **TX overflow:** with `tx_ready`=0, write 0x41..0x49 (9 bytes, DEPTH 8) → STATUS=0x10 (bit4 set, tx_not_full=0), `irq`=1. Raise `tx_ready` → 0x41..0x48 emitted on consecutive cycles.
- **RX ordering and overrun:** inject 9 bytes 0x10..0x18 with no reads → bit5 set, bit3 set. Eight RXDATA reads return 0x10..0x17. A ninth read returns 0.
- **Simultaneous events on full RX:** RXDATA read in the same cycle as `rx_valid` → no overrun, occupancy stays 8.
- **Interrupt enables and W1C:** IRQEN=1 with one RX byte → `irq`=1. Read RXDATA → `irq`=0 two cycles later. Write STATUS 0x30 → sticky flags clear.
- **Stats (`UART_MMIO_STATS_EN`):** send 3 TX bytes and drop 2 RX bytes → 0x10 reads 0x0002_0003. Write 0x10 → reads 0.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared register offsets, STATUS/IRQEN bit positions and the STATUS payload layout
// for the memory-mapped UART FIFO front end.
package uart_mmio_pkg;

  localparam int unsigned OFF_W = 5;

  localparam logic [OFF_W-1:0] OFF_STATUS = 5'h00;
  localparam logic [OFF_W-1:0] OFF_RXDATA = 5'h04;
  localparam logic [OFF_W-1:0] OFF_TXDATA = 5'h08;
  localparam logic [OFF_W-1:0] OFF_IRQEN  = 5'h0C;
  localparam logic [OFF_W-1:0] OFF_STATS  = 5'h10;

  localparam int unsigned ST_TX_NOT_FULL  = 0;
  localparam int unsigned ST_RX_NOT_EMPTY = 1;
  localparam int unsigned ST_TX_EMPTY     = 2;
  localparam int unsigned ST_RX_FULL      = 3;
  localparam int unsigned ST_TX_OVERFLOW  = 4;
  localparam int unsigned ST_RX_OVERRUN   = 5;

  localparam int unsigned IE_RX_NOT_EMPTY = 0;
  localparam int unsigned IE_TX_EMPTY     = 1;

  localparam int unsigned STATUS_W = 6;

  // Field order mirrors the STATUS bit positions (MSB first).
  typedef struct packed {
    logic rx_overrun;
    logic tx_overflow;
    logic rx_full;
    logic tx_empty;
    logic rx_not_empty;
    logic tx_not_full;
  } status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push-when-full and pop-when-empty are
// ignored, while push+pop on a full FIFO is accepted.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is not reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front end: address decode, TX/RX FIFOs, sticky error flags and IRQ.
// Optional STATS register at 0x10 when UART_MMIO_STATS_EN is defined.
module uart_mmio_fifo
  import uart_mmio_pkg::*;
#(
  parameter int unsigned TX_DEPTH  = 8,
  parameter int unsigned RX_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic        re,
  output logic        hit,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  logic [OFF_W-1:0] off;
  logic             acc_wr;
  logic             acc_rd;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_full;
  logic             tx_empty;
  logic             rx_pop;
  logic             rx_full;
  logic             rx_empty;
  logic [7:0]       rx_head;
  logic             tx_ovf_evt;
  logic             rx_ovr_evt;
  logic             status_wr;
  logic             tx_overflow;
  logic             rx_overrun;
  logic [1:0]       irqen;
  status_t          status;
  logic [31:0]      stats_word;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign off       = addr[OFF_W-1:0];
  assign hit       = (addr[31:5] == BASE_ADDR[31:5]);
  assign acc_wr    = we && hit;
  assign acc_rd    = re && hit;
  assign unused_wd = ^wd[31:8];

  assign tx_push   = acc_wr && (off == OFF_TXDATA);
  assign tx_valid  = !tx_empty;
  assign tx_pop    = tx_valid && tx_ready;
  assign rx_pop    = acc_rd && (off == OFF_RXDATA);
  assign rx_ready  = 1'b1;
  assign status_wr = acc_wr && (off == OFF_STATUS);

  // Drops only happen when no same-cycle pop makes room.
  assign tx_ovf_evt = tx_push && tx_full && !tx_pop;
  assign rx_ovr_evt = rx_valid && rx_full && !rx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_ready),
    .din   (wd[7:0]),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    status              = '0;
    status.tx_not_full  = !tx_full;
    status.rx_not_empty = !rx_empty;
    status.tx_empty     = tx_empty;
    status.rx_full      = rx_full;
    status.tx_overflow  = tx_overflow;
    status.rx_overrun   = rx_overrun;
  end

  // Sticky flags: a new event in the same cycle as W1C keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_overflow <= 1'b0;
      rx_overrun  <= 1'b0;
      irqen       <= '0;
    end else begin
      tx_overflow <= tx_ovf_evt || (tx_overflow && !(status_wr && wd[ST_TX_OVERFLOW]));
      rx_overrun  <= rx_ovr_evt || (rx_overrun  && !(status_wr && wd[ST_RX_OVERRUN]));
      if (acc_wr && (off == OFF_IRQEN)) irqen <= wd[1:0];
    end
  end

`ifdef UART_MMIO_STATS_EN
  logic [15:0] tx_byte_count;
  logic [15:0] rx_drop_count;
  logic        stats_clr;

  assign stats_clr  = acc_wr && (off == OFF_STATS);
  assign stats_word = {rx_drop_count, tx_byte_count};

  // Saturating counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_byte_count <= '0;
      rx_drop_count <= '0;
    end else if (stats_clr) begin
      tx_byte_count <= '0;
      rx_drop_count <= '0;
    end else begin
      if (tx_pop && (tx_byte_count != 16'hFFFF)) tx_byte_count <= tx_byte_count + 16'd1;
      if (rx_ovr_evt && (rx_drop_count != 16'hFFFF)) rx_drop_count <= rx_drop_count + 16'd1;
    end
  end
`else
  assign stats_word = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_STATUS: rd_mux = 32'(status);
      OFF_RXDATA: rd_mux = rx_empty ? 32'h0 : {24'h0, rx_head};
      OFF_IRQEN:  rd_mux = {30'h0, irqen};
      OFF_STATS:  rd_mux = stats_word;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (acc_rd) rdata <= rd_mux;
      irq <= (irqen[IE_RX_NOT_EMPTY] && !rx_empty) ||
             (irqen[IE_TX_EMPTY] && tx_empty) || tx_overflow || rx_overrun;
    end
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Bench for uart_mmio_fifo: directed scenarios plus a random phase, all checked against
// a queue-based model of the register map.
module tb_uart_mmio_fifo;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int TXD = 8;
  localparam int RXD = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] wdv;
  logic        wev;
  logic        rev;
  logic        hit;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        txr;
  logic [7:0]  rxd;
  logic        rxv;
  logic        rx_ready;
  logic        irq;

  uart_mmio_fifo dut (
    .clk      (clk),
    .rst      (rst_n),
    .addr     (a),
    .wd       (wdv),
    .we       (wev),
    .re       (rev),
    .hit      (hit),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (txr),
    .rx_data  (rxd),
    .rx_valid (rxv),
    .rx_ready (rx_ready),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic        txov;
  logic        rxov;
  logic [1:0]  ie;
  logic        irq_m;
  logic [31:0] rdata_m;
  logic [15:0] tx_cnt;
  logic [15:0] rx_cnt;

  logic [31:0] v;
  logic [4:0]  offs [9] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h1C, 5'h08, 5'h04};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] off);
    logic [31:0] r;
    r = '0;
    case (off)
      5'h00: r = {26'b0, rxov, txov, rx_q.size() == RXD, tx_q.size() == 0,
                  rx_q.size() != 0, tx_q.size() != TXD};
      5'h04: r = (rx_q.size() != 0) ? {24'b0, rx_q[0]} : 32'h0;
      5'h0C: r = {30'b0, ie};
`ifdef UART_MMIO_STATS_EN
      5'h10: r = {rx_cnt, tx_cnt};
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // One clock: check combinational outputs, advance model and DUT, check registered outputs.
  task automatic step();
    logic        hitm;
    logic        rdq;
    logic        wrq;
    logic        txpop;
    logic        rxpop;
    logic        irq_next;
    logic [4:0]  off;
    logic [31:0] rv;
    #1;
    hitm = (a[31:5] == BASE[31:5]);
    chk("hit", {31'b0, hit}, {31'b0, hitm});
    chk("tx_valid", {31'b0, tx_valid}, {31'b0, tx_q.size() != 0});
    if (tx_q.size() != 0) chk("tx_data", {24'b0, tx_data}, {24'b0, tx_q[0]});
    chk("rx_ready", {31'b0, rx_ready}, 32'h1);
    off = a[4:0];
    rdq = rev && hitm;
    wrq = wev && hitm;
    rv = model_read(off);
    txpop = (tx_q.size() != 0) && txr;
    rxpop = rdq && (off == 5'h04) && (rx_q.size() != 0);
    irq_next = (ie[0] && rx_q.size() != 0) || (ie[1] && tx_q.size() == 0) || txov || rxov;
    @(posedge clk);
    #1;
    if (txpop) begin
      void'(tx_q.pop_front());
      if (tx_cnt != 16'hFFFF) tx_cnt++;
    end
    if (rxpop) void'(rx_q.pop_front());
    if (wrq && off == 5'h00) begin
      if (wdv[4]) txov = 1'b0;
      if (wdv[5]) rxov = 1'b0;
    end
    if (wrq && off == 5'h08) begin
      if (tx_q.size() < TXD) tx_q.push_back(wdv[7:0]);
      else txov = 1'b1;
    end
    if (rxv) begin
      if (rx_q.size() < RXD) rx_q.push_back(rxd);
      else begin
        rxov = 1'b1;
        if (rx_cnt != 16'hFFFF) rx_cnt++;
      end
    end
    if (wrq && off == 5'h0C) ie = wdv[1:0];
    if (wrq && off == 5'h10) begin
      tx_cnt = '0;
      rx_cnt = '0;
    end
    irq_m = irq_next;
    if (rdq) rdata_m = rv;
    chk("irq", {31'b0, irq}, {31'b0, irq_m});
    chk("rdata", rdata, rdata_m);
  endtask

  task automatic model_clear();
    tx_q.delete();
    rx_q.delete();
    txov = 0; rxov = 0; ie = '0; irq_m = 0; rdata_m = '0; tx_cnt = '0; rx_cnt = '0;
  endtask

  task automatic do_reset();
    wev = 0; rev = 0; rxv = 0; txr = 0; a = BASE; wdv = '0; rxd = '0;
    rst_n = 1'b0;
    #1;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic mmio_wr(input logic [4:0] off, input logic [31:0] d);
    a = BASE | {27'b0, off}; wdv = d; wev = 1; rev = 0;
    step();
    wev = 0;
  endtask

  task automatic mmio_rd(input logic [4:0] off, output logic [31:0] r);
    a = BASE | {27'b0, off}; rev = 1; wev = 0;
    step();
    rev = 0;
    r = rdata;
  endtask

  initial begin
    rst_n = 1'b1;
    do_reset();
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);

    // Reset asserted in the middle of a TX burst
    for (int i = 0; i < 4; i++) mmio_wr(5'h08, 32'hA0 + i);
    mmio_rd(5'h00, v);
    txr = 1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_mid_irq", {31'b0, irq}, 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_rx_ready", {31'b0, rx_ready}, 32'h1);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    txr = 0;
    mmio_rd(5'h00, v);
    chk("rst_status", v, 32'h05);
    step();
    chk("rst_irq_after", {31'b0, irq}, 32'h0);

    // TX overflow, then drain at one byte per cycle
    do_reset();
    for (int i = 0; i < 9; i++) mmio_wr(5'h08, 32'h41 + i);
    mmio_rd(5'h00, v);
    chk("ovf_status", v, 32'h10);
    step();
    chk("ovf_irq", {31'b0, irq}, 32'h1);
    txr = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("ovf_drain", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'(32'h41 + i)});
      step();
    end
    txr = 0;
    step();
    chk("ovf_drained", {31'b0, tx_valid}, 32'h0);
    mmio_wr(5'h00, 32'h30);

    // RX ordering and overrun
    do_reset();
    for (int i = 0; i < 9; i++) begin
      rxv = 1; rxd = 8'(32'h10 + i);
      step();
    end
    rxv = 0;
    mmio_rd(5'h00, v);
    chk("rx_ovr_status", v & 32'h28, 32'h28);
    for (int i = 0; i < 8; i++) begin
      mmio_rd(5'h04, v);
      chk("rx_order", v, 32'h10 + i);
    end
    mmio_rd(5'h04, v);
    chk("rx_empty_read", v, 32'h0);

    // Read and arrival in the same cycle on a full RX FIFO
    mmio_wr(5'h00, 32'h20);
    for (int i = 0; i < 8; i++) begin
      rxv = 1; rxd = 8'(32'h80 + i);
      step();
    end
    rxv = 1; rxd = 8'h99;
    mmio_rd(5'h04, v);
    rxv = 0;
    chk("simul_rd", v, 32'h80);
    mmio_rd(5'h00, v);
    chk("simul_status", v, 32'h0F);
    for (int i = 0; i < 8; i++) mmio_rd(5'h04, v);
    chk("simul_last", v, 32'h99);

    // Empty RX: read and arrival together returns 0 and stores the byte
    rxv = 1; rxd = 8'h3C;
    mmio_rd(5'h04, v);
    rxv = 0;
    chk("rx_empty_simul", v, 32'h0);
    mmio_rd(5'h04, v);
    chk("rx_empty_simul_kept", v, 32'h3C);

    // Interrupt enables
    do_reset();
    mmio_wr(5'h0C, 32'h1);
    rxv = 1; rxd = 8'h5A;
    step();
    rxv = 0;
    step();
    chk("irq_rx", {31'b0, irq}, 32'h1);
    mmio_rd(5'h04, v);
    step();
    chk("irq_rx_clear", {31'b0, irq}, 32'h0);
    mmio_wr(5'h0C, 32'h2);
    step();
    chk("irq_tx_empty", {31'b0, irq}, 32'h1);
    mmio_rd(5'h0C, v);
    chk("irqen_read", v, 32'h2);
    mmio_wr(5'h0C, 32'h0);

    // W1C racing a fresh overrun: the set wins
    for (int i = 0; i < 9; i++) mmio_wr(5'h08, 32'h60 + i);
    for (int i = 0; i < 9; i++) begin
      rxv = 1; rxd = 8'(32'h20 + i);
      step();
    end
    rxv = 1; rxd = 8'hEE;
    mmio_wr(5'h00, 32'h30);
    rxv = 0;
    mmio_rd(5'h00, v);
    chk("w1c_race", v, 32'h2A);
    mmio_wr(5'h00, 32'h30);
    mmio_rd(5'h00, v);
    chk("w1c_clear", v, 32'h0A);

    // Out-of-window accesses are ignored and rdata holds
    a = 32'h0000_0008; wdv = 32'h77; wev = 1;
    step();
    wev = 0;
    a = 32'h0000_0004; rev = 1;
    step();
    rev = 0;
    chk("miss_hold", rdata, 32'h0A);

    // Statistics register
    do_reset();
    for (int i = 0; i < 3; i++) mmio_wr(5'h08, 32'hC0 + i);
    txr = 1;
    for (int i = 0; i < 3; i++) step();
    txr = 0;
    for (int i = 0; i < 10; i++) begin
      rxv = 1; rxd = 8'(i);
      step();
    end
    rxv = 0;
    mmio_rd(5'h10, v);
`ifdef UART_MMIO_STATS_EN
    chk("stats_count", v, 32'h0002_0003);
`else
    chk("stats_absent", v, 32'h0);
`endif
    mmio_wr(5'h10, 32'h0);
    mmio_rd(5'h10, v);
    chk("stats_clear", v, 32'h0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) a = 32'h0000_0008;
      else a = BASE | {27'b0, offs[$urandom_range(0, 8)]};
      wev = ($urandom_range(0, 2) == 0);
      rev = !wev && ($urandom_range(0, 1) == 0);
      wdv = $urandom;
      txr = ($urandom_range(0, 2) == 0);
      rxv = ($urandom_range(0, 2) == 0);
      rxd = 8'($urandom);
      step();
    end
    wev = 0; rev = 0; rxv = 0; txr = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
